// File: rtl/mips_pkg.sv
// Shared pipeline definitions: default bus widths and dump-sequencer FSM encoding.
// Consumers import with mips_pkg::*.
package mips_pkg;

    localparam int NB_DATA_DEF = 32;
    localparam int NB_ADDR_DEF = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_SEND  = 3'd2;
    localparam logic [2:0] ST_CSUM  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/dmem_dump_arbiter.sv
// Data-memory arbiter: the CPU owns the RAM port; a dump sequencer streams words out in free cycles.
// Optional trailing XOR checksum word when DMEM_DUMP_CHECKSUM_EN is defined. Latency 2 cycles/word, valid held until ready.
module dmem_dump_arbiter
    import mips_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_ADDR = NB_ADDR_DEF,
    parameter int N_DUMP  = 256
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_cpu_we,
    input  logic               i_cpu_re,
    input  logic [NB_ADDR-1:0] i_cpu_addr,
    input  logic [NB_DATA-1:0] i_cpu_wdata,
    output logic [NB_DATA-1:0] o_cpu_rdata,
    input  logic               i_dump_start,
    input  logic               i_dump_ready,
    output logic               o_dump_valid,
    output logic [NB_DATA-1:0] o_dump_data,
    output logic [NB_ADDR-1:0] o_dump_addr,
    output logic               o_dump_busy,
    output logic               o_dump_done,
    output logic               o_mem_we,
    output logic [NB_ADDR-1:0] o_mem_addr,
    output logic [NB_DATA-1:0] o_mem_wdata,
    input  logic [NB_DATA-1:0] i_mem_rdata
);

    // One extra pointer bit so N_DUMP == 2**NB_ADDR reaches its last index without wrapping.
    localparam logic [NB_ADDR:0] LAST_PTR = (NB_ADDR+1)'(N_DUMP - 1);

    logic [2:0]         r_state;
    logic [NB_ADDR:0]   r_ptr;
    logic [NB_DATA-1:0] r_data;
    logic [NB_ADDR-1:0] r_addr;
    logic               w_cpu_acc;
    logic               w_last;

    assign w_cpu_acc = i_cpu_we | i_cpu_re;
    assign w_last    = (r_ptr == LAST_PTR);

`ifdef DMEM_DUMP_CHECKSUM_EN
    logic [NB_DATA-1:0] r_csum;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_csum <= '0;
        end else if (r_state == ST_IDLE && i_dump_start) begin
            r_csum <= '0;
        end else if (r_state == ST_SEND && i_dump_ready) begin
            r_csum <= r_csum ^ r_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_data  <= '0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_dump_start) begin
                        r_ptr   <= '0;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // A CPU access owns the RAM port this cycle, so the fetch simply retries.
                    if (!w_cpu_acc) begin
                        r_data  <= i_mem_rdata;
                        r_addr  <= r_ptr[NB_ADDR-1:0];
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (i_dump_ready) begin
                        if (w_last) begin
`ifdef DMEM_DUMP_CHECKSUM_EN
                            r_state <= ST_CSUM;
`else
                            r_state <= ST_DONE;
`endif
                        end else begin
                            r_ptr   <= r_ptr + 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end
                end
`ifdef DMEM_DUMP_CHECKSUM_EN
                ST_CSUM: begin
                    if (i_dump_ready) begin
                        r_state <= ST_DONE;
                    end
                end
`endif
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_mem_addr = i_cpu_addr;
        if (!w_cpu_acc && r_state == ST_FETCH) begin
            o_mem_addr = r_ptr[NB_ADDR-1:0];
        end
    end

    assign o_mem_we    = i_cpu_we;
    assign o_mem_wdata = i_cpu_wdata;
    assign o_cpu_rdata = i_mem_rdata;

    assign o_dump_busy = (r_state != ST_IDLE);
    assign o_dump_done = (r_state == ST_DONE);

`ifdef DMEM_DUMP_CHECKSUM_EN
    assign o_dump_valid = (r_state == ST_SEND) || (r_state == ST_CSUM);
    assign o_dump_data  = (r_state == ST_CSUM) ? r_csum : r_data;
    assign o_dump_addr  = (r_state == ST_CSUM) ? {NB_ADDR{1'b1}} : r_addr;
`else
    assign o_dump_valid = (r_state == ST_SEND);
    assign o_dump_data  = r_data;
    assign o_dump_addr  = r_addr;
`endif

endmodule
